// File: rtl/syn_gpu_pkg.sv
// Shared GPU-level types: pixel-coordinate pointers, LIFO entry type and the
// LIFO memory-agent state encoding.
package syn_gpu_pkg;

  localparam int LF_DATA_W = 16;
  localparam int PT_X_W    = 10;
  localparam int PT_Y_W    = 9;

  // Pixel address as carried on the pointer and SRAM buses: {y,x}.
  typedef struct packed {
    logic [PT_Y_W-1:0] y;
    logic [PT_X_W-1:0] x;
  } point_t;

  typedef logic [LF_DATA_W-1:0] lf_data_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT,
    RD_RSP,
    SETTLE
  } lf_agent_st_t;

endpackage

// File: rtl/syn_gpu_lf_mem_agent.sv
// Turns fill-engine LIFO push/pop requests into single outstanding SRAM ops,
// steering the pointer controller and returning popped entries to the client.
module syn_gpu_lf_mem_agent
  import syn_gpu_pkg::*;
#(
  parameter int P_DATA_W = LF_DATA_W,
  parameter int P_X_W    = PT_X_W,
  parameter int P_Y_W    = PT_Y_W
) (
  input  logic                     clk_ir,
  input  logic                     rst_sync,
  input  logic                     push_valid,
  input  logic [P_DATA_W-1:0]      push_data,
  output logic                     push_ready,
  input  logic                     pop_valid,
  output logic                     pop_ready,
  output logic                     pop_rsp_valid,
  output logic [P_DATA_W-1:0]      pop_rsp_data,
  output logic                     lf_wr_en,
  output logic                     lf_rd_en,
  input  logic                     lf_full,
  input  logic                     lf_empty,
  input  logic [P_X_W+P_Y_W-1:0]   lf_waddr,
  input  logic [P_X_W+P_Y_W-1:0]   lf_raddr,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_wr,
  output logic [P_X_W+P_Y_W-1:0]   mem_req_addr,
  output logic [P_DATA_W-1:0]      mem_req_wdata,
  input  logic                     mem_rsp_valid,
  input  logic [P_DATA_W-1:0]      mem_rsp_data,
  output logic                     err_unexp_rsp
);

  localparam int A_W = P_X_W + P_Y_W;

  lf_agent_st_t        state_q, state_d;
  logic [A_W-1:0]      addr_q;
  logic [P_DATA_W-1:0] wdata_q;
  logic [P_DATA_W-1:0] rdata_q;
  logic                err_q;

  logic push_acc;
  logic pop_acc;

  // Accepts only happen from IDLE; push wins when both are requested.
  assign push_acc = (state_q == IDLE) && push_valid && !lf_full && !rst_sync;
  assign pop_acc  = (state_q == IDLE) && pop_valid && !push_valid && !lf_empty && !rst_sync;

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path through it leaves a signal unassigned, which would infer a latch.
    state_d       = state_q;
    push_ready    = 1'b0;
    pop_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    lf_wr_en      = 1'b0;
    lf_rd_en      = 1'b0;
    pop_rsp_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        push_ready = !lf_full;
        pop_ready  = !lf_empty && !push_valid;
        if (push_valid && !lf_full) begin
          state_d = WR_REQ;
        end else if (pop_valid && !lf_empty) begin
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        if (mem_req_ready) begin
          lf_wr_en = 1'b1;
          state_d  = SETTLE;
        end
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          lf_rd_en = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        pop_rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      SETTLE: begin
        // Pointer controller outputs are registered; give them one cycle.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The reset is synchronous, so during the reset cycle state_q may still
    // hold an in-flight op; mask every handshake/strobe so nothing leaks out.
    if (rst_sync) begin
      state_d       = IDLE;
      push_ready    = 1'b0;
      pop_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_wr    = 1'b0;
      lf_wr_en      = 1'b0;
      lf_rd_en      = 1'b0;
      pop_rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_ir) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of the order the simulator evaluates blocks.
    if (rst_sync) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (push_acc) begin
        addr_q  <= lf_waddr;
        wdata_q <= push_data;
      end else if (pop_acc) begin
        addr_q  <= lf_raddr;
      end

      if (mem_rsp_valid) begin
        if (state_q == RD_WAIT) begin
          rdata_q <= mem_rsp_data;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign pop_rsp_data  = rdata_q;
  assign err_unexp_rsp = err_q;

endmodule

// File: tb/tb_syn_gpu_lf_mem_agent.sv
// Self-checking bench: stack reference model + SRAM/pointer-controller models,
// scoreboard queues checked by an independent monitor.
module tb_syn_gpu_lf_mem_agent;

  localparam int DW    = 16;
  localparam int XW    = 10;
  localparam int YW    = 9;
  localparam int AW    = XW + YW;
  localparam int DEPTH = 8;

  logic          clk_ir = 1'b0;
  logic          rst_sync;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_valid;
  logic          pop_ready;
  logic          pop_rsp_valid;
  logic [DW-1:0] pop_rsp_data;
  logic          lf_wr_en;
  logic          lf_rd_en;
  logic          lf_full;
  logic          lf_empty;
  logic [AW-1:0] lf_waddr;
  logic [AW-1:0] lf_raddr;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_wr;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          err_unexp_rsp;

  always #5 clk_ir = ~clk_ir;

  syn_gpu_lf_mem_agent dut (
    .clk_ir        (clk_ir),
    .rst_sync      (rst_sync),
    .push_valid    (push_valid),
    .push_data     (push_data),
    .push_ready    (push_ready),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_rsp_valid (pop_rsp_valid),
    .pop_rsp_data  (pop_rsp_data),
    .lf_wr_en      (lf_wr_en),
    .lf_rd_en      (lf_rd_en),
    .lf_full       (lf_full),
    .lf_empty      (lf_empty),
    .lf_waddr      (lf_waddr),
    .lf_raddr      (lf_raddr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_wr    (mem_req_wr),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .err_unexp_rsp (err_unexp_rsp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired or impossible event (t=%0t)", name, $time);
  endtask

  // Stack slot i lives at pixel {y=i/4, x=i%4}.
  function automatic logic [AW-1:0] loc(input int i);
    logic [YW-1:0] y;
    logic [XW-1:0] x;
    y = YW'(i / 4);
    x = XW'(i % 4);
    return {y, x};
  endfunction

  // ---------------- pointer controller model ----------------
  int ptr_cnt = 0;
  bit force_full = 1'b0;

  always @(posedge clk_ir) begin
    if (rst_sync) ptr_cnt <= 0;
    else if (lf_wr_en) ptr_cnt <= ptr_cnt + 1;
    else if (lf_rd_en) ptr_cnt <= ptr_cnt - 1;
  end

  assign lf_full  = force_full || (ptr_cnt >= DEPTH);
  assign lf_empty = (ptr_cnt <= 0);
  assign lf_waddr = loc(ptr_cnt);
  assign lf_raddr = loc(ptr_cnt - 1);

  // ---------------- SRAM arbiter model ----------------
  bit ready_hold = 1'b0;
  bit rand_ready = 1'b0;
  int forced_lat = 0;

  initial begin
    mem_req_ready = 1'b1;
    forever begin
      @(posedge clk_ir);
      #1;
      mem_req_ready = ready_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  logic [DW-1:0] sram [logic [AW-1:0]];
  int            resp_lat;
  logic [AW-1:0] resp_addr;

  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clk_ir);
      if (mem_req_valid && mem_req_ready && !rst_sync) begin
        if (mem_req_wr) begin
          sram[mem_req_addr] = mem_req_wdata;
        end else begin
          resp_lat  = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 3));
          resp_addr = mem_req_addr;
          repeat (resp_lat) @(posedge clk_ir);
          #1;
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = sram.exists(resp_addr) ? sram[resp_addr] : 16'hDEAD;
          @(posedge clk_ir);
          #1;
          mem_rsp_valid = 1'b0;
          mem_rsp_data  = '0;
        end
      end
    end
  end

  // ---------------- reference model (LIFO of entries) ----------------
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  logic [DW-1:0] stack[$];
  logic [DW-1:0] exp_rsp[$];
  req_t          exp_req[$];

  int cyc = 0;
  int push_acc_cyc = 0;
  int pop_acc_cyc  = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;

  always @(posedge clk_ir) cyc <= cyc + 1;

  always @(negedge clk_ir) begin
    if (rst_sync) begin
      stack.delete();
      exp_rsp.delete();
      exp_req.delete();
    end else if (push_valid && push_ready) begin
      exp_req.push_back('{1'b1, loc(stack.size()), push_data});
      stack.push_back(push_data);
      push_acc_cyc = cyc;
    end else if (pop_valid && pop_ready) begin
      if (stack.size() == 0) begin
        fail("pop_accepted_when_empty");
      end else begin
        exp_req.push_back('{1'b0, loc(stack.size() - 1), '0});
        exp_rsp.push_back(stack.pop_back());
      end
      pop_acc_cyc = cyc;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          prev_stall = 1'b0;
  logic          prev_wr;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdata;
  req_t          got_req;
  logic [DW-1:0] want_data;

  always @(negedge clk_ir) begin
    if (!rst_sync) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          fail("unexpected_mem_req");
        end else begin
          got_req = exp_req.pop_front();
          check("mem_req_wr", mem_req_wr, got_req.wr);
          check("mem_req_addr", mem_req_addr, got_req.addr);
          if (got_req.wr) check("mem_req_wdata", mem_req_wdata, got_req.data);
        end
      end
      if (lf_wr_en || lf_rd_en || (mem_req_valid && mem_req_ready)) begin
        check("lf_wr_en_on_handshake", lf_wr_en, mem_req_valid && mem_req_ready && mem_req_wr);
        check("lf_rd_en_on_handshake", lf_rd_en, mem_req_valid && mem_req_ready && !mem_req_wr);
      end
      if (lf_wr_en) wr_pulses++;
      if (lf_rd_en) rd_pulses++;
      if (prev_stall) begin
        check("req_held_while_stalled", {mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata},
              {1'b1, prev_wr, prev_addr, prev_wdata});
      end
      if (pop_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          fail("unexpected_pop_rsp");
        end else begin
          want_data = exp_rsp.pop_front();
          check("pop_rsp_data", pop_rsp_data, want_data);
        end
      end
      if (push_ready) check("push_ready_needs_not_full", lf_full, 1'b0);
      if (pop_ready) check("pop_ready_needs_nonempty_no_push", {lf_empty, push_valid}, 2'b00);
    end
    prev_stall = !rst_sync && mem_req_valid && !mem_req_ready;
    prev_wr    = mem_req_wr;
    prev_addr  = mem_req_addr;
    prev_wdata = mem_req_wdata;
  end

  // ---------------- stimulus ----------------
  task automatic do_push(input logic [DW-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_ir);
      if (push_ready) begin
        @(posedge clk_ir);
        #1;
        push_valid = 1'b0;
        return;
      end
    end
    fail("push_accept_timeout");
    push_valid = 1'b0;
  endtask

  task automatic do_pop();
    pop_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_ir);
      if (pop_ready) begin
        @(posedge clk_ir);
        #1;
        pop_valid = 1'b0;
        return;
      end
    end
    fail("pop_accept_timeout");
    pop_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_ir);
      if (exp_req.size() == 0 && exp_rsp.size() == 0) begin
        repeat (2) @(posedge clk_ir);
        #1;
        return;
      end
    end
    fail("drain_timeout");
  endtask

  int wr0, rd0;
  bit got;

  initial begin
    rst_sync   = 1'b1;
    push_valid = 1'b1;
    pop_valid  = 1'b1;
    push_data  = 16'hFFFF;
    repeat (3) @(posedge clk_ir);
    @(negedge clk_ir);
    check("rst_push_ready", push_ready, 1'b0);
    check("rst_pop_ready", pop_ready, 1'b0);
    check("rst_outputs", {mem_req_valid, mem_req_wr, lf_wr_en, lf_rd_en, pop_rsp_valid, err_unexp_rsp},
          6'b0);
    check("rst_data_outputs", {mem_req_addr, mem_req_wdata, pop_rsp_data}, '0);
    @(posedge clk_ir);
    #1;
    push_valid = 1'b0;
    pop_valid  = 1'b0;
    rst_sync   = 1'b0;

    // Single push, latency back to ready.
    wr0 = wr_pulses;
    do_push(16'hA5A5);
    @(negedge clk_ir);
    check("push_ready_in_wr_req", push_ready, 1'b0);
    @(negedge clk_ir);
    check("push_ready_in_settle", push_ready, 1'b0);
    @(negedge clk_ir);
    check("push_ready_back_after_3", push_ready, 1'b1);
    drain();
    check("one_wr_pulse", wr_pulses - wr0, 1);

    // Two pushes then two pops come back in reverse order.
    do_push(16'h1111);
    do_push(16'h2222);
    drain();
    rd0 = rd_pulses;
    do_pop();
    do_pop();
    drain();
    check("two_rd_pulses", rd_pulses - rd0, 2);

    // Arbiter stalls the write for 5 cycles.
    ready_hold = 1'b1;
    repeat (2) @(posedge clk_ir);
    #1;
    wr0 = wr_pulses;
    do_push(16'h3333);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_ir);
      check("stall_req_valid", mem_req_valid, 1'b1);
      check("stall_addr", mem_req_addr, loc(1));
      check("stall_wdata", mem_req_wdata, 16'h3333);
      check("stall_no_wr_en", lf_wr_en, 1'b0);
    end
    ready_hold = 1'b0;
    drain();
    check("stall_one_wr_pulse", wr_pulses - wr0, 1);

    // Full pointer controller blocks pushes.
    force_full = 1'b1;
    push_valid = 1'b1;
    push_data  = 16'h7777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_ir);
      check("full_push_ready", push_ready, 1'b0);
      check("full_no_mem_req", mem_req_valid, 1'b0);
    end
    @(posedge clk_ir);
    #1;
    push_valid = 1'b0;
    force_full = 1'b0;

    // Push and pop together: push first, pop three cycles later.
    push_valid = 1'b1;
    push_data  = 16'h4444;
    pop_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_ir);
      got = push_ready;
    end
    if (!got) fail("simul_push_timeout");
    @(posedge clk_ir);
    #1;
    push_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_ir);
      got = pop_ready;
    end
    if (!got) fail("simul_pop_timeout");
    @(posedge clk_ir);
    #1;
    pop_valid = 1'b0;
    check("pop_after_settle_gap", pop_acc_cyc - push_acc_cyc, 3);
    drain();

    // Empty the stack, then an empty controller blocks pops.
    while (stack.size() > 0) begin
      do_pop();
      drain();
    end
    pop_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_ir);
      check("empty_pop_ready", pop_ready, 1'b0);
      check("empty_no_mem_req", mem_req_valid, 1'b0);
    end
    @(posedge clk_ir);
    #1;
    pop_valid = 1'b0;

    // Randomised traffic with a stalling arbiter.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (stack.size() < DEPTH && (stack.size() == 0 || $urandom_range(0, 1) == 1))
        do_push(16'($urandom));
      else
        do_pop();
      if ($urandom_range(0, 7) == 0) drain();
    end
    drain();
    rand_ready = 1'b0;
    check("ptr_matches_model_depth", ptr_cnt, stack.size());
    check("no_err_in_normal_traffic", err_unexp_rsp, 1'b0);

    // Reset while waiting for read data; the late response must be flagged.
    do_push(16'h5A5A);
    drain();
    forced_lat = 8;
    do_pop();
    repeat (3) @(posedge clk_ir);
    #1;
    rst_sync = 1'b1;
    @(posedge clk_ir);
    #1;
    rst_sync = 1'b0;
    @(negedge clk_ir);
    check("err_clear_after_reset", err_unexp_rsp, 1'b0);
    repeat (6) @(posedge clk_ir);
    @(negedge clk_ir);
    check("err_late_rsp", err_unexp_rsp, 1'b1);
    check("idle_after_reset_push_ready", push_ready, 1'b1);
    check("idle_after_reset_no_req", mem_req_valid, 1'b0);
    forced_lat = 0;

    // Reset clears the sticky error; agent still works afterwards.
    @(posedge clk_ir);
    #1;
    rst_sync = 1'b1;
    repeat (2) @(posedge clk_ir);
    #1;
    rst_sync = 1'b0;
    @(negedge clk_ir);
    check("err_cleared_by_reset", err_unexp_rsp, 1'b0);
    do_push(16'hBEEF);
    do_pop();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
